// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period sequencer: video lead-in, active video and data-island scheduling.
// Define HDMI_DATA_ISLAND_EN to schedule data islands; leave it undefined for DVI-only output.
module hdmi_period_scheduler #(
    parameter int H_ACTIVE     = 1280,
    parameter int H_TOTAL      = 1650,
    parameter int V_ACTIVE     = 720,
    parameter int V_TOTAL      = 750,
    parameter int ISLAND_START = 1300,
    parameter int MAX_PKTS     = 2
) (
    input  logic        clk_pix,
    input  logic        rst,
    input  logic [10:0] counterX,
    input  logic [9:0]  counterY,
    input  logic        pkt_valid,
    output logic [2:0]  period,
    output logic [3:0]  ctl,
    output logic [4:0]  di_idx,
    output logic        pkt_start,
    output logic        pkt_done,
    output logic        island_active
);

`ifdef HDMI_DATA_ISLAND_EN
    localparam bit ISLAND_EN = 1'b1;
`else
    localparam bit ISLAND_EN = 1'b0;
`endif

    localparam logic [10:0] X_ACTIVE = 11'(H_ACTIVE);
    localparam logic [10:0] X_TOTAL  = 11'(H_TOTAL);
    localparam logic [10:0] X_ISLAND = 11'(ISLAND_START);
    localparam logic [10:0] X_PRE    = 11'(H_TOTAL - 10);
    localparam logic [10:0] X_GB     = 11'(H_TOTAL - 2);
    localparam logic [9:0]  Y_ACTIVE = 10'(V_ACTIVE);
    localparam logic [9:0]  Y_TOTAL  = 10'(V_TOTAL);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [2:0]  PKT_MAX  = 3'(MAX_PKTS);

    if (ISLAND_START < H_ACTIVE + 12) begin : g_err_island_start
        $error("hdmi_period_scheduler: ISLAND_START must be >= H_ACTIVE+12");
    end
    if (ISLAND_START + 24 + 32 * MAX_PKTS > H_TOTAL - 10) begin : g_err_island_len
        $error("hdmi_period_scheduler: data island overlaps the video lead-in");
    end
    if (MAX_PKTS < 1 || MAX_PKTS > 4) begin : g_err_max_pkts
        $error("hdmi_period_scheduler: MAX_PKTS must be in 1..4");
    end

    typedef enum logic [2:0] {
        ST_CTRL, ST_DI_PRE, ST_DI_GB_LEAD, ST_DI_DATA, ST_DI_GB_TRAIL
    } state_t;

    typedef enum logic [2:0] {
        P_CTRL    = 3'd0,
        P_VID_PRE = 3'd1,
        P_VID_GB  = 3'd2,
        P_VIDEO   = 3'd3,
        P_DI_PRE  = 3'd4,
        P_DI_GB   = 3'd5,
        P_DI_DATA = 3'd6
    } period_t;

    // state/cnt describe the pixel already on the outputs; *_n describe the pixel now sampled
    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [2:0]  pkt_cnt, pkt_cnt_n;
    logic        more, more_n;
    logic        in_range, video_led;
    logic [9:0]  next_row;
    period_t     period_n;
    logic [3:0]  ctl_n;
    logic [4:0]  di_idx_n;
    logic        pkt_start_n, pkt_done_n, island_n;

    assign in_range  = (counterX < X_TOTAL) && (counterY < Y_TOTAL);
    assign next_row  = (counterY == Y_LAST) ? 10'd0 : counterY + 10'd1;
    assign video_led = next_row < Y_ACTIVE;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_n     = state;
        cnt_n       = cnt;
        pkt_cnt_n   = pkt_cnt;
        more_n      = more;
        pkt_start_n = 1'b0;
        pkt_done_n  = 1'b0;
        if (in_range) begin
            unique case (state)
                ST_CTRL: begin
                    if (ISLAND_EN && counterX == X_ISLAND && pkt_valid) begin
                        state_n = ST_DI_PRE;
                        cnt_n   = 5'd0;
                    end
                end
                ST_DI_PRE: begin
                    if (cnt == 5'd7) begin
                        state_n = ST_DI_GB_LEAD;
                        cnt_n   = 5'd0;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
                ST_DI_GB_LEAD: begin
                    if (cnt == 5'd1) begin
                        state_n     = ST_DI_DATA;
                        cnt_n       = 5'd0;
                        pkt_start_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
                ST_DI_DATA: begin
                    if (cnt == 5'd31) begin
                        cnt_n = 5'd0;
                        if (more) pkt_start_n = 1'b1;
                        else      state_n     = ST_DI_GB_TRAIL;
                    end else begin
                        cnt_n = cnt + 5'd1;
                        // The continue decision is taken on the word-31 pixel itself.
                        if (cnt == 5'd30) begin
                            pkt_done_n = 1'b1;
                            pkt_cnt_n  = pkt_cnt + 3'd1;
                            more_n     = pkt_valid && ((pkt_cnt + 3'd1) < PKT_MAX);
                        end
                    end
                end
                ST_DI_GB_TRAIL: begin
                    if (cnt == 5'd1) begin
                        state_n   = ST_CTRL;
                        cnt_n     = 5'd0;
                        pkt_cnt_n = 3'd0;
                        more_n    = 1'b0;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
                default: state_n = ST_CTRL;
            endcase
        end
    end

    always_comb begin
        period_n = P_CTRL;
        ctl_n    = 4'b0000;
        di_idx_n = 5'd0;
        island_n = 1'b0;
        if (in_range) begin
            if (counterX < X_ACTIVE && counterY < Y_ACTIVE) begin
                period_n = P_VIDEO;
            end else if (video_led && counterX >= X_GB) begin
                period_n = P_VID_GB;
            end else if (video_led && counterX >= X_PRE) begin
                period_n = P_VID_PRE;
                ctl_n    = 4'b0001;
            end
            unique case (state_n)
                ST_DI_PRE: begin
                    period_n = P_DI_PRE;
                    ctl_n    = 4'b0101;
                    island_n = 1'b1;
                end
                ST_DI_GB_LEAD, ST_DI_GB_TRAIL: begin
                    period_n = P_DI_GB;
                    island_n = 1'b1;
                end
                ST_DI_DATA: begin
                    period_n = P_DI_DATA;
                    di_idx_n = cnt_n;
                    island_n = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state         <= ST_CTRL;
            cnt           <= 5'd0;
            pkt_cnt       <= 3'd0;
            more          <= 1'b0;
            period        <= 3'd0;
            ctl           <= 4'b0000;
            di_idx        <= 5'd0;
            pkt_start     <= 1'b0;
            pkt_done      <= 1'b0;
            island_active <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state         <= state_n;
            cnt           <= cnt_n;
            pkt_cnt       <= pkt_cnt_n;
            more          <= more_n;
            period        <= period_n;
            ctl           <= ctl_n;
            di_idx        <= di_idx_n;
            pkt_start     <= pkt_start_n;
            pkt_done      <= pkt_done_n;
            island_active <= island_n;
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Self-checking bench for hdmi_period_scheduler: vector table plus full-line sequences.
// Island expectations follow HDMI_DATA_ISLAND_EN; in DVI builds no island is expected.
module tb_hdmi_period_scheduler;

`ifdef HDMI_DATA_ISLAND_EN
    localparam bit ISL_EN = 1'b1;
`else
    localparam bit ISL_EN = 1'b0;
`endif

    logic        clk_pix = 1'b0;
    logic        rst;
    logic [10:0] counterX;
    logic [9:0]  counterY;
    logic        pkt_valid;
    logic [2:0]  period;
    logic [3:0]  ctl;
    logic [4:0]  di_idx;
    logic        pkt_start, pkt_done, island_active;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_pix = ~clk_pix;

    hdmi_period_scheduler dut (
        .clk_pix      (clk_pix),
        .rst          (rst),
        .counterX     (counterX),
        .counterY     (counterY),
        .pkt_valid    (pkt_valid),
        .period       (period),
        .ctl          (ctl),
        .di_idx       (di_idx),
        .pkt_start    (pkt_start),
        .pkt_done     (pkt_done),
        .island_active(island_active)
    );

    typedef struct {
        int         x;
        int         y;
        logic       v;
        logic [2:0] period;
        logic [3:0] ctl;
    } vec_t;

    vec_t vecs[20];

    // Packed as {period, ctl, di_idx, pkt_start, pkt_done, island_active}.
    function automatic logic [14:0] act_out();
        return {period, ctl, di_idx, pkt_start, pkt_done, island_active};
    endfunction

    // Expected outputs for pixel (x, y) on a line carrying npk packets from x=1300.
    function automatic logic [14:0] exp_out(input int x, input int y, input int npk);
        logic [2:0] p;
        logic [3:0] c;
        logic [4:0] idx;
        logic       s, d, i;
        int         nr, d_end;
        p = 3'd0; c = 4'd0; idx = 5'd0; s = 1'b0; d = 1'b0; i = 1'b0;
        if (x < 1650 && y < 750) begin
            nr = (y == 749) ? 0 : y + 1;
            if (x < 1280 && y < 720)          p = 3'd3;
            else if (nr < 720 && x >= 1648)   p = 3'd2;
            else if (nr < 720 && x >= 1640) begin
                p = 3'd1;
                c = 4'b0001;
            end
            if (npk > 0) begin
                d_end = 1310 + 32 * npk;
                if (x >= 1300 && x <= 1307) begin
                    p = 3'd4; c = 4'b0101; i = 1'b1;
                end else if ((x >= 1308 && x <= 1309) || (x >= d_end && x <= d_end + 1)) begin
                    p = 3'd5; i = 1'b1;
                end else if (x >= 1310 && x < d_end) begin
                    p = 3'd6; idx = 5'((x - 1310) % 32);
                    s = (idx == 5'd0); d = (idx == 5'd31); i = 1'b1;
                end
            end
        end
        return {p, c, idx, s, d, i};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got period=%0d ctl=%b idx=%0d start=%b done=%b island=%b, want period=%0d ctl=%b idx=%0d start=%b done=%b island=%b",
                     name, act[14:12], act[11:8], act[7:3], act[2], act[1], act[0],
                     exp[14:12], exp[11:8], exp[7:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Present one pixel's inputs, clock, then sample that pixel's registered outputs.
    task automatic step(input int x, input int y, input logic v);
        counterX  = 11'(x);
        counterY  = 10'(y);
        pkt_valid = v;
        @(posedge clk_pix);
        #1;
    endtask

    // mode: 0 valid high, 1 valid high for x<1341, 2 valid high for x>=1301, 3 valid low.
    // rst_x >= 0 asserts reset right after pixel rst_x and releases it after the next pixel.
    task automatic run_line(input int y, input int mode, input int npk, input int rst_x);
        int          starts, dones, exp_starts, exp_dones, n_live;
        logic        v;
        logic [14:0] e;
        starts = 0; dones = 0; exp_starts = 0; exp_dones = 0; n_live = npk;
        for (int x = 0; x < 1650; x++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (x < 1341);
                2:       v = (x >= 1301);
                default: v = 1'b0;
            endcase
            step(x, y, v);
            if (rst_x >= 0 && x == rst_x + 1) begin
                check($sformatf("rst_hold_y%0d_x%0d", y, x), act_out(), 15'd0);
                rst    = 1'b0;
                n_live = 0;
            end else begin
                e = exp_out(x, y, n_live);
                check($sformatf("pix_y%0d_x%0d", y, x), act_out(), e);
                exp_starts += int'(e[2]);
                exp_dones  += int'(e[1]);
                starts     += int'(pkt_start);
                dones      += int'(pkt_done);
                if (x == rst_x) begin
                    rst = 1'b1;
                    #1;
                    check($sformatf("rst_async_y%0d_x%0d", y, x), act_out(), 15'd0);
                end
            end
        end
        check_int($sformatf("pkt_start_count_y%0d", y), starts, exp_starts);
        check_int($sformatf("pkt_done_count_y%0d", y), dones, exp_dones);
    endtask

    initial begin
        vecs[0]  = '{100,  0,   1'b0, 3'd3, 4'b0000};
        vecs[1]  = '{0,    0,   1'b0, 3'd3, 4'b0000};
        vecs[2]  = '{1279, 719, 1'b0, 3'd3, 4'b0000};
        vecs[3]  = '{1280, 0,   1'b0, 3'd0, 4'b0000};
        vecs[4]  = '{1300, 0,   1'b0, 3'd0, 4'b0000};
        vecs[5]  = '{1639, 0,   1'b0, 3'd0, 4'b0000};
        vecs[6]  = '{1640, 0,   1'b1, 3'd1, 4'b0001};
        vecs[7]  = '{1647, 0,   1'b0, 3'd1, 4'b0001};
        vecs[8]  = '{1648, 0,   1'b0, 3'd2, 4'b0000};
        vecs[9]  = '{1649, 0,   1'b0, 3'd2, 4'b0000};
        vecs[10] = '{1640, 719, 1'b0, 3'd0, 4'b0000};
        vecs[11] = '{1648, 719, 1'b0, 3'd0, 4'b0000};
        vecs[12] = '{1640, 718, 1'b0, 3'd1, 4'b0001};
        vecs[13] = '{1640, 748, 1'b0, 3'd0, 4'b0000};
        vecs[14] = '{1640, 749, 1'b0, 3'd1, 4'b0001};
        vecs[15] = '{1649, 749, 1'b0, 3'd2, 4'b0000};
        vecs[16] = '{0,    749, 1'b0, 3'd0, 4'b0000};
        vecs[17] = '{500,  720, 1'b0, 3'd0, 4'b0000};
        vecs[18] = '{1700, 0,   1'b0, 3'd0, 4'b0000};
        vecs[19] = '{0,    800, 1'b0, 3'd0, 4'b0000};

        rst       = 1'b1;
        counterX  = 11'd0;
        counterY  = 10'd0;
        pkt_valid = 1'b1;
        repeat (2) @(posedge clk_pix);
        #1;
        check("reset_state", act_out(), 15'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].x, vecs[i].y, vecs[i].v);
            check($sformatf("vec%0d_x%0d_y%0d", i, vecs[i].x, vecs[i].y), act_out(),
                  {vecs[i].period, vecs[i].ctl, 8'd0});
        end

        run_line(100, 0, ISL_EN ? 2 : 0, -1);
        run_line(101, 1, ISL_EN ? 1 : 0, -1);
        run_line(102, 2, 0, -1);
        run_line(103, 0, ISL_EN ? 2 : 0, -1);
        run_line(104, 0, ISL_EN ? 2 : 0, 1320);
        run_line(105, 0, ISL_EN ? 2 : 0, -1);
        run_line(719, 3, 0, -1);
        run_line(730, 0, ISL_EN ? 2 : 0, -1);
        run_line(749, 0, ISL_EN ? 2 : 0, -1);
        run_line(0,   3, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Per-pixel HDMI period sequencer feeding the TMDS datapath.
- Each pixel it selects one period: control, video preamble, video guard band, active video, data-island preamble, data-island guard band or data-island payload.
- It drives the CTL preamble bits, schedules up to MAX_PKTS 32-cycle packets per line from a packet source, and sits between the video timer and the TMDS encode/mux stage.

Parameters:
- H_ACTIVE, 1280, active pixels per line; de is high for counterX in [0, H_ACTIVE-1].
- H_TOTAL, 1650, pixels per line.
- V_ACTIVE, 720, active lines; de is high only on rows counterY < V_ACTIVE.
- V_TOTAL, 750, lines per frame.
- ISLAND_START, 1300, counterX at which a data-island preamble may begin.
- MAX_PKTS, 2, maximum packets per island (1..4).

Ports:
- clk_pix  in  1  pixel clock.
- rst  in  1  reset; asynchronous, active-high.
- counterX  in  11  horizontal pixel count from the video timer.
- counterY  in  10  vertical line count from the video timer.
- pkt_valid  in  1  level signal: a packet is held ready by the source.
- period  out  3  period code: 0 CTRL, 1 VID_PRE, 2 VID_GB, 3 VIDEO, 4 DI_PRE, 5 DI_GB, 6 DI_DATA.
- ctl  out  4  CTL3..CTL0 preamble bits.
- di_idx  out  5  payload word index 0..31 within the current packet.
- pkt_start  out  1  one-cycle pulse on the first payload cycle (packet accepted).
- pkt_done  out  1  one-cycle pulse on payload cycle 31 (source may advance).
- island_active  out  1  high during DI_PRE, DI_GB and DI_DATA.

Behaviour:
- Reset (async): period=0, ctl=0, di_idx=0, pkt_start=0, pkt_done=0, island_active=0, packet count=0. An island in progress is abandoned, pkt_done is not pulsed, and the source keeps its packet.
- Latency: every output is registered. Inputs sampled with counterX=x produce, one cycle later, the outputs for pixel x, aligned with the registered TMDS words.
- next_row is 0 when counterY=V_TOTAL-1, otherwise counterY+1. A line is "video-led" when next_row < V_ACTIVE.
- Video lead-in, video-led lines only:
  - counterX in [H_TOTAL-10, H_TOTAL-3]: VID_PRE, ctl=4'b0001.
  - counterX in [H_TOTAL-2, H_TOTAL-1]: VID_GB.
- VIDEO when counterX < H_ACTIVE and counterY < V_ACTIVE.
- FSM states: CTRL, DI_PRE(8), DI_GB_LEAD(2), DI_DATA(32×n), DI_GB_TRAIL(2).
  - CTRL -> DI_PRE: at counterX=ISLAND_START with pkt_valid=1, on any line including vertical blanking. ctl=4'b0101 during DI_PRE.
  - DI_PRE -> DI_GB_LEAD after 8 cycles.
  - DI_GB_LEAD -> DI_DATA after 2 cycles; pkt_start pulses on the first payload cycle.
  - DI_DATA: di_idx counts 0..31 and wraps to 0. At di_idx=31, pkt_done pulses and the packet count increments.
  - Continue to the next packet if pkt_valid=1 at di_idx=31 and count < MAX_PKTS; pkt_start pulses on the following cycle. Otherwise go to DI_GB_TRAIL.
  - DI_GB_TRAIL -> CTRL after 2 cycles; packet count clears.
- pkt_valid is ignored outside the ISLAND_START cycle and the di_idx=31 cycle. If pkt_valid drops mid-packet, the packet still completes all 32 cycles.
- At most one island per line. If pkt_valid is low at ISLAND_START, no island is sent that line.
- ctl=0 in every period other than VID_PRE and DI_PRE. di_idx=0 outside DI_DATA.
- Elaboration checks (assertion or $error):
  - ISLAND_START ≥ H_ACTIVE+12.
  - ISLAND_START + 12 + 32·MAX_PKTS + 12 ≤ H_TOTAL-10.
  - With these satisfied, an island can never collide with the video lead-in.
- counterX ≥ H_TOTAL or counterY ≥ V_TOTAL: treat as CTRL, with no state change.

Optional Feature:
- HDMI_DATA_ISLAND_EN defined: islands are scheduled as above.
- Undefined (DVI mode): the FSM stays in CTRL; period is only 0..3; pkt_start, pkt_done and island_active are tied 0; pkt_valid is ignored.

Test Plan:
- Reset asserted mid-DI_DATA (di_idx=10) -> all outputs 0 next cycle, no pkt_done; after release the island restarts on the next line at counterX=1300.
- counterY=719 -> no VID_PRE at x=1640..1647. counterY=749 -> VID_PRE (ctl=0001) at x=1640..1647, VID_GB at x=1648..1649, VIDEO at x=0 of row 0.
- pkt_valid held high, MAX_PKTS=2 -> DI_PRE (ctl=0101) at x=1300..1307, DI_GB at 1308..1309, DI_DATA at 1310..1373 with two pkt_start/pkt_done pairs, DI_GB at 1374..1375, CTRL from 1376.
- pkt_valid high at x=1300, low by x=1341 -> single packet at 1310..1341, trailing guard at 1342..1343, one pkt_done.
- pkt_valid low at x=1300, high from x=1301 -> no island that line; island starts at x=1300 of the next line.
- Build without HDMI_DATA_ISLAND_EN, pkt_valid=1 -> period never exceeds 3 over a full frame; pkt_start never pulses.
